// File: rtl/neopixel_pkg.sv
// Shared types and default WS2812 timing for the neopixel driver.
package neopixel_pkg;

    typedef enum logic [1:0] {
        GREEN = 2'd0,
        RED   = 2'd1,
        BLUE  = 2'd2
    } color_index_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_LATCH = 2'd2
    } drv_state_t;

    localparam int DEF_NUM_PIXELS = 5;
    localparam int DEF_T0H        = 20;
    localparam int DEF_T1H        = 40;
    localparam int DEF_TBIT       = 62;
    localparam int DEF_TLATCH     = 2500;
    localparam int BITS_PER_PIXEL = 24;

    function automatic logic color_valid(input logic [1:0] idx);
        return idx <= BLUE;
    endfunction

endpackage

// File: rtl/neopixel_driver_if.sv
// Producer-to-driver bundle: colour loads and frame requests in, serial line and status out.
interface neopixel_driver_if;
    logic       load_color;
    logic [2:0] pixel_index;
    logic [1:0] color_index;
    logic [7:0] color_level;
    logic       send_it;
    logic       neo_data;
    logic       ready_to_load;
    logic       ready_to_send;
    logic       begin_send;
    logic       done_send;
    logic       done_wait;

    modport master (
        output load_color, pixel_index, color_index, color_level, send_it,
        input  neo_data, ready_to_load, ready_to_send, begin_send, done_send, done_wait
    );

    modport slave (
        input  load_color, pixel_index, color_index, color_level, send_it,
        output neo_data, ready_to_load, ready_to_send, begin_send, done_send, done_wait
    );
endinterface

// File: rtl/neopixel_driver_bit_encoder.sv
// One WS2812 bit period: line high for T0H/T1H cycles, low to the end of TBIT, bit_done on the last cycle.
module neo_bit_encoder
    import neopixel_pkg::*;
#(
    parameter int T0H  = DEF_T0H,
    parameter int T1H  = DEF_T1H,
    parameter int TBIT = DEF_TBIT
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic bit_val,
    output logic level,
    output logic bit_done
);

    localparam int PH_W = $clog2(TBIT);

    logic            active;
    logic            active_d;
    logic            level_d;
    logic            last;
    logic [PH_W-1:0] phase;
    logic [PH_W-1:0] phase_d;
    logic [PH_W-1:0] high_len;

    assign last     = (phase == PH_W'(TBIT - 1));
    assign bit_done = active && last;
    assign phase_d  = last ? '0 : phase + 1'b1;
    assign high_len = bit_val ? PH_W'(T1H) : PH_W'(T0H);

    neo_counter #(.W(PH_W)) u_phase (
        .clock (clock),
        .reset (reset),
        .en    (active),
        .clear (start),
        .d     (phase_d),
        .q     (phase)
    );

    // level is registered one cycle ahead: it is computed for the phase about to start
    always_comb begin
        active_d = active;
        level_d  = 1'b0;
        if (start) begin
            active_d = 1'b1;
            level_d  = 1'b1;
        end else if (active) begin
            if (last) begin
                active_d = 1'b0;
            end else begin
                level_d = (phase_d < high_len);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active <= 1'b0;
            level  <= 1'b0;
        end else begin
            active <= active_d;
            level  <= level_d;
        end
    end

endmodule

// File: rtl/neopixel_driver_counter.sv
// Shared counter register: clear has priority, otherwise load d when enabled.
module neo_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/neopixel_driver.sv
// WS2812 frame buffer and serialiser for a NUM_PIXELS chain (GRB, MSB first).
// Define NEOPIXEL_DBUF_EN for a shadow buffer so loads stay open while a frame is sent.
//
// state    | meaning
// ST_IDLE  | accepting loads and send requests
// ST_SEND  | serialising NUM_PIXELS*24 bits
// ST_LATCH | line held low for TLATCH cycles
module neopixel_driver
    import neopixel_pkg::*;
#(
    parameter int NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int T0H        = DEF_T0H,
    parameter int T1H        = DEF_T1H,
    parameter int TBIT       = DEF_TBIT,
    parameter int TLATCH     = DEF_TLATCH
) (
    input  logic             clock,
    input  logic             reset,
    neopixel_driver_if.slave bus
);

    localparam int NBITS = NUM_PIXELS * BITS_PER_PIXEL;
    localparam int BI_W  = $clog2(NBITS);
    localparam int LA_W  = $clog2(TLATCH);

    drv_state_t       state;
    drv_state_t       state_d;
    logic             send_accept;
    logic             load_ok;
    logic             wr_en;
    logic             enc_start;
    logic             bit_done;
    logic             bit_val;
    logic             last_bit;
    logic             frame_done;
    logic             latch_done;
    logic             begin_q;
    logic             enc_level;
    logic [BI_W-1:0]  bit_idx;
    logic [LA_W-1:0]  latch_cnt;
    logic [7:0]       pix_mem  [NUM_PIXELS][3];
    logic [7:0]       mem_next [NUM_PIXELS][3];
    logic [7:0]       rd_mem   [NUM_PIXELS][3];
    logic [NBITS-1:0] frame_bits;

    assign send_accept = (state == ST_IDLE) && bus.send_it;
    assign last_bit    = (bit_idx == BI_W'(NBITS - 1));
    assign frame_done  = (state == ST_SEND) && bit_done && last_bit;
    assign latch_done  = (state == ST_LATCH) && (latch_cnt == LA_W'(TLATCH - 1));

`ifdef NEOPIXEL_DBUF_EN
    assign load_ok = 1'b1;
`else
    assign load_ok = (state == ST_IDLE);
`endif

    assign wr_en = bus.load_color && load_ok
                 && (int'(bus.pixel_index) < NUM_PIXELS)
                 && color_valid(bus.color_index);

    always_comb begin
        mem_next = pix_mem;
        if (wr_en) begin
            mem_next[bus.pixel_index][bus.color_index] = bus.color_level;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PIXELS; p++) begin
                for (int c = 0; c < 3; c++) begin
                    pix_mem[p][c] <= '0;
                end
            end
        end else begin
            pix_mem <= mem_next;
        end
    end

`ifdef NEOPIXEL_DBUF_EN
    logic [7:0] shadow_mem [NUM_PIXELS][3];

    // snapshot includes a load arriving in the same cycle as send_it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PIXELS; p++) begin
                for (int c = 0; c < 3; c++) begin
                    shadow_mem[p][c] <= '0;
                end
            end
        end else if (send_accept) begin
            shadow_mem <= mem_next;
        end
    end

    assign rd_mem = shadow_mem;
`else
    assign rd_mem = pix_mem;
`endif

    // flatten into transmit order so the bit counter indexes directly
    always_comb begin
        frame_bits = '0;
        for (int p = 0; p < NUM_PIXELS; p++) begin
            for (int c = 0; c < 3; c++) begin
                for (int j = 0; j < 8; j++) begin
                    frame_bits[p*BITS_PER_PIXEL + c*8 + j] = rd_mem[p][c][7-j];
                end
            end
        end
    end

    assign bit_val = frame_bits[bit_idx];

    always_comb begin
        state_d   = state;
        enc_start = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.send_it) begin
                    state_d   = ST_SEND;
                    enc_start = 1'b1;
                end
            end
            ST_SEND: begin
                if (bit_done) begin
                    if (last_bit) begin
                        state_d = ST_LATCH;
                    end else begin
                        enc_start = 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                if (latch_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            begin_q <= 1'b0;
        end else begin
            state   <= state_d;
            begin_q <= send_accept;
        end
    end

    neo_counter #(.W(BI_W)) u_bit_cnt (
        .clock (clock),
        .reset (reset),
        .en    ((state == ST_SEND) && bit_done),
        .clear (send_accept),
        .d     (bit_idx + 1'b1),
        .q     (bit_idx)
    );

    neo_counter #(.W(LA_W)) u_latch_cnt (
        .clock (clock),
        .reset (reset),
        .en    (state == ST_LATCH),
        .clear (frame_done),
        .d     (latch_cnt + 1'b1),
        .q     (latch_cnt)
    );

    neo_bit_encoder #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_encoder (
        .clock    (clock),
        .reset    (reset),
        .start    (enc_start),
        .bit_val  (bit_val),
        .level    (enc_level),
        .bit_done (bit_done)
    );

    assign bus.neo_data      = enc_level;
    assign bus.ready_to_send = (state == ST_IDLE);
    assign bus.ready_to_load = load_ok;
    assign bus.begin_send    = begin_q;
    assign bus.done_send     = frame_done;
    assign bus.done_wait     = latch_done;

endmodule
